// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory with byte-stream program loader and core reset control

module imem_loader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_o,
   input  logic              boot_skip,
   input  logic              ld_start,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic [ADDR_W-1:0] ld_len,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              ld_busy,
   output logic              ld_error,
   output logic              cpu_reset_
);

   localparam int DEPTH = 1 << ADDR_W;

   // one extra bit so a full-depth load (ld_len == 0) can be counted down
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_RUN,
      S_ERR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   remaining;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              xfer;
   logic              wr_en;
   logic              can_start;
   logic [ADDR_W:0]   start_count;

   assign xfer        = ld_valid && ld_ready;
   assign wr_en       = xfer && (state == S_LOAD);
   assign can_start   = ld_start && ((state == S_IDLE) || (state == S_RUN) || (state == S_ERR));
   assign start_count = (ld_len == '0) ? CNT_FULL : {1'b0, ld_len};

   // memory write port; contents survive reset so a warm boot can reuse them
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[waddr] <= ld_data;
      end
   end

   // zero-latency fetch read, masked to 0 whenever the core is not running
   always_comb begin
      inst_o = '0;
      if (state == S_RUN) begin
         inst_o = mem[inst_addr];
      end
   end

   // loader FSM; ld_ready, ld_busy, ld_error and cpu_reset_ are flops set on state-entry edges
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state      <= S_IDLE;
         waddr      <= '0;
         remaining  <= '0;
         sum        <= '0;
         ld_error   <= 1'b0;
         cpu_reset_ <= 1'b0;
         ld_ready   <= 1'b0;
         ld_busy    <= 1'b0;
      end else begin
         if (can_start) begin
            // ld_start beats boot_skip; a restart from RUN drops core reset on this edge
            state      <= S_LOAD;
            waddr      <= ld_base;
            remaining  <= start_count;
            sum        <= '0;
            ld_error   <= 1'b0;
            cpu_reset_ <= 1'b0;
            ld_ready   <= 1'b1;
            ld_busy    <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (boot_skip) begin
                     state      <= S_RUN;
                     cpu_reset_ <= 1'b1;
                  end
               end
               S_LOAD: begin
                  if (xfer) begin
                     waddr     <= waddr + ADDR_ONE;
                     sum       <= sum + ld_data;
                     remaining <= remaining - CNT_ONE;
                     if (remaining == CNT_ONE) begin
                        state <= S_CHECK;
                     end
                  end
               end
               S_CHECK: begin
                  // the checksum byte is compared only, never written to memory
                  if (xfer) begin
                     ld_ready <= 1'b0;
                     ld_busy  <= 1'b0;
                     if (ld_data == sum) begin
                        state      <= S_RUN;
                        cpu_reset_ <= 1'b1;
                     end else begin
                        state    <= S_ERR;
                        ld_error <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  state <= S_RUN;
               end
               S_ERR: begin
                  state <= S_ERR;
               end
               default: begin
                  state      <= S_IDLE;
                  cpu_reset_ <= 1'b0;
                  ld_ready   <= 1'b0;
                  ld_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader

module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset_ = 1'b0;
   logic [11:0] inst_addr = '0;
   logic [7:0]  inst_o;
   logic        boot_skip = 1'b0;
   logic        ld_start = 1'b0;
   logic [11:0] ld_base = '0;
   logic [11:0] ld_len = '0;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_data = '0;
   logic        ld_ready;
   logic        ld_busy;
   logic        ld_error;
   logic        cpu_reset_;

   typedef struct {
      string      tag;
      logic [7:0] inst;
      logic       cpu;
      logic       err;
      logic       busy;
      bit         force_fail;
   } exp_t;

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;

   imem_loader #(.ADDR_W(12), .DATA_W(8)) dut (
      .clk        (clk),
      .reset_     (reset_),
      .inst_addr  (inst_addr),
      .inst_o     (inst_o),
      .boot_skip  (boot_skip),
      .ld_start   (ld_start),
      .ld_base    (ld_base),
      .ld_len     (ld_len),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .ld_busy    (ld_busy),
      .ld_error   (ld_error),
      .cpu_reset_ (cpu_reset_)
   );

   always #5 clk = ~clk;

   // monitor: drain every expectation queued this cycle and compare away from the active edge
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t r;
         r = exp_q.pop_front();
         compared++;
         if (r.force_fail || inst_o !== r.inst || cpu_reset_ !== r.cpu || ld_error !== r.err ||
             ld_busy !== r.busy || ld_ready !== r.busy) begin
            mismatched++;
            $display("FAIL %s: got inst=%h cpu_reset_=%b err=%b busy=%b ready=%b, want inst=%h cpu_reset_=%b err=%b busy=ready=%b%s",
                     r.tag, inst_o, cpu_reset_, ld_error, ld_busy, ld_ready,
                     r.inst, r.cpu, r.err, r.busy, r.force_fail ? " (handshake timeout)" : "");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] inst, input logic cpu,
                             input logic err, input logic busy);
      exp_t r;
      r.tag = tag; r.inst = inst; r.cpu = cpu; r.err = err; r.busy = busy; r.force_fail = 1'b0;
      exp_q.push_back(r);
   endtask

   task automatic peek(input string tag, input logic [11:0] addr, input logic [7:0] inst,
                       input logic cpu, input logic err, input logic busy);
      inst_addr = addr;
      expect_out(tag, inst, cpu, err, busy);
      tick();
   endtask

   task automatic start_load(input logic [11:0] base, input logic [11:0] len);
      ld_base  = base;
      ld_len   = len;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      int n;
      n = 0;
      while (!ld_ready && n < 16) begin
         tick();
         n++;
      end
      if (!ld_ready) begin
         exp_t r;
         r.tag = "send_wait"; r.inst = 8'h00; r.cpu = 1'b0; r.err = 1'b0; r.busy = 1'b1;
         r.force_fail = 1'b1;
         exp_q.push_back(r);
      end
      ld_valid = 1'b1;
      ld_data  = d;
      tick();
      ld_valid = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      peek("reset_state", 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
      reset_ = 1'b1;
      tick();

      // good load at 0x000, cpu_reset_ must rise only on the checksum edge
      start_load(12'h000, 12'd3);
      peek("load1_busy", 12'h001, 8'h00, 1'b0, 1'b0, 1'b1);
      send(8'h10); send(8'h20); send(8'h30);
      inst_addr = 12'h001;
      ld_valid  = 1'b1;
      ld_data   = 8'h60;
      expect_out("pre_accept", 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      ld_valid = 1'b0;
      peek("run1_read", 12'h001, 8'h20, 1'b1, 1'b0, 1'b0);
      compared++;
      if (inst_o !== 8'h20 || ld_error !== 1'b0) begin
         mismatched++;
         $display("FAIL run1_direct: inst=%h err=%b", inst_o, ld_error);
      end

      // restart from RUN drops reset on the start edge, then bad checksum
      start_load(12'h000, 12'd3);
      peek("restart_cpu", 12'h001, 8'h00, 1'b0, 1'b0, 1'b1);
      send(8'h10); send(8'h20); send(8'h30); send(8'h61);
      peek("bad_sum_err", 12'h001, 8'h00, 1'b0, 1'b1, 1'b0);
      boot_skip = 1'b1;
      peek("err_skip_a", 12'h001, 8'h00, 1'b0, 1'b1, 1'b0);
      peek("err_skip_b", 12'h001, 8'h00, 1'b0, 1'b1, 1'b0);
      boot_skip = 1'b0;
      start_load(12'h000, 12'd3);
      peek("err_cleared", 12'h001, 8'h00, 1'b0, 1'b0, 1'b1);
      send(8'h10); send(8'h20); send(8'h30); send(8'h60);
      peek("run2_read", 12'h001, 8'h20, 1'b1, 1'b0, 1'b0);

      // address wrap across the top of memory
      start_load(12'hFFE, 12'd4);
      send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); send(8'h8A);
      peek("wrap_ffe", 12'hFFE, 8'hA1, 1'b1, 1'b0, 1'b0);
      peek("wrap_fff", 12'hFFF, 8'hA2, 1'b1, 1'b0, 1'b0);
      peek("wrap_000", 12'h000, 8'hA3, 1'b1, 1'b0, 1'b0);
      peek("wrap_001", 12'h001, 8'hA4, 1'b1, 1'b0, 1'b0);
      peek("wrap_002", 12'h002, 8'h30, 1'b1, 1'b0, 1'b0);

      // preload 0x100..0x102, then a short load with gaps and an ignored ld_start
      start_load(12'h100, 12'd3);
      send(8'h11); send(8'h22); send(8'h33); send(8'h66);
      start_load(12'h100, 12'd2);
      send(8'h05);
      ld_data = 8'hEE;
      tick();
      ld_base  = 12'h200;
      ld_len   = 12'd5;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      peek("gap_busy", 12'h100, 8'h00, 1'b0, 1'b0, 1'b1);
      send(8'h07);
      peek("in_check", 12'h100, 8'h00, 1'b0, 1'b0, 1'b1);
      send(8'h0C);
      peek("gap_run", 12'h100, 8'h05, 1'b1, 1'b0, 1'b0);
      peek("gap_101", 12'h101, 8'h07, 1'b1, 1'b0, 1'b0);
      peek("gap_102", 12'h102, 8'h33, 1'b1, 1'b0, 1'b0);

      // asynchronous reset mid-cycle, then warm boot with boot_skip
      @(posedge clk);
      #2;
      reset_ = 1'b0;
      inst_addr = 12'h100;
      #1;
      compared++;
      if (cpu_reset_ !== 1'b0 || inst_o !== 8'h00) begin
         mismatched++;
         $display("FAIL async_immediate: cpu_reset_=%b inst=%h", cpu_reset_, inst_o);
      end
      expect_out("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      reset_ = 1'b1;
      boot_skip = 1'b1;
      tick();
      boot_skip = 1'b0;
      peek("warm_ffe", 12'hFFE, 8'hA1, 1'b1, 1'b0, 1'b0);
      peek("warm_100", 12'h100, 8'h05, 1'b1, 1'b0, 1'b0);

      // ld_start wins over boot_skip in IDLE
      reset_ = 1'b0;
      tick();
      reset_ = 1'b1;
      boot_skip = 1'b1;
      start_load(12'h300, 12'd1);
      boot_skip = 1'b0;
      peek("prio_load", 12'h300, 8'h00, 1'b0, 1'b0, 1'b1);
      send(8'h42); send(8'h42);
      peek("prio_run", 12'h300, 8'h42, 1'b1, 1'b0, 1'b0);

      // full-depth load (ld_len 0) from nonzero base wraps without error
      start_load(12'h005, 12'd0);
      for (int k = 0; k < 4096; k++) begin
         if (k == 4095) begin
            peek("full_busy", 12'h005, 8'h00, 1'b0, 1'b0, 1'b1);
         end
         send(8'(k));
      end
      peek("full_check", 12'h005, 8'h00, 1'b0, 1'b0, 1'b1);
      send(8'h00);
      peek("full_005", 12'h005, 8'h00, 1'b1, 1'b0, 1'b0);
      peek("full_004", 12'h004, 8'hFF, 1'b1, 1'b0, 1'b0);
      peek("full_000", 12'h000, 8'hFB, 1'b1, 1'b0, 1'b0);
      peek("full_fff", 12'hFFF, 8'hFA, 1'b1, 1'b0, 1'b0);

      repeat (2) tick();
      if (mismatched != 0) begin
         $display("FAIL summary: %0d mismatches", mismatched);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory responder for the fetch unit. It serves the fetch unit's 12-bit instruction address with an 8-bit instruction byte.
- It also owns the write side of instruction memory: a byte-stream program loader with a valid/ready handshake and checksum check.
- It holds the CPU in reset until a program is loaded and verified.
- It sits between the program source (UART/host bridge) and the fetch unit, and drives the core's reset_.

Parameters:
- ADDR_W, 12, instruction address width; memory depth is 2**ADDR_W bytes.
- DATA_W, 8, instruction byte width.

Ports:
- clk  input  1  core clock
- reset_  input  1  asynchronous active-low reset
- inst_addr  input  ADDR_W  fetch-side read address
- inst_o  output  DATA_W  fetch-side instruction byte
- boot_skip  input  1  in IDLE, go straight to RUN with existing memory contents
- ld_start  input  1  single-cycle request to begin a load
- ld_base  input  ADDR_W  first write address, sampled with ld_start
- ld_len  input  ADDR_W  data byte count, sampled with ld_start; 0 means 2**ADDR_W
- ld_valid  input  1  ld_data valid
- ld_data  input  DATA_W  data or checksum byte
- ld_ready  output  1  loader accepts a byte this cycle
- ld_busy  output  1  state is LOAD or CHECK
- ld_error  output  1  last load failed its checksum
- cpu_reset_  output  1  active-low reset to the core; high only in RUN

Behaviour:
- Reset: asynchronous, active-low, clocked on the posedge of clk. While reset_ is low:
  - state=IDLE; waddr, remaining count and sum are 0.
  - ld_error=0, cpu_reset_=0, ld_ready=0, ld_busy=0.
  - Memory contents are not cleared.
- Read path: combinational, zero latency. inst_o = mem[inst_addr] whenever state==RUN, otherwise 0. The fetch unit samples inst_o in the same cycle it drives inst_addr.
- Handshake: a byte transfers on a clk edge where ld_valid && ld_ready. ld_ready = (state==LOAD || state==CHECK), with no backpressure inside those states. ld_data is ignored when no transfer occurs.
- IDLE:
  - ld_start=1 -> LOAD. Latch waddr=ld_base, remaining=ld_len (0 treated as 2**ADDR_W), sum=0, ld_error=0.
  - Otherwise boot_skip=1 -> RUN.
  - ld_start has priority over boot_skip.
- LOAD, per transfer:
  - mem[waddr] <= ld_data.
  - waddr <= waddr+1, modulo 2**ADDR_W (wraps from all-ones to 0).
  - sum <= sum+ld_data, modulo 2**DATA_W.
  - remaining decrements; on the transfer where remaining==1 -> CHECK.
- CHECK: the next transferred byte is the checksum and is not written.
  - Equal to sum -> RUN.
  - Unequal -> ERR with ld_error=1.
- RUN: cpu_reset_=1. ld_start=1 -> LOAD, as in IDLE; cpu_reset_ drops to 0 on that same edge.
- ERR: cpu_reset_=0, ld_error=1, inst_o=0.
  - ld_start -> LOAD and clears ld_error.
  - boot_skip is ignored.
- cpu_reset_ is a dedicated flop, not a state decode. It is set on the same edge the state enters RUN, so it is glitch-free.
- ld_start while in LOAD or CHECK is ignored; ld_base and ld_len are not re-sampled.
- Reset mid-load: abort immediately to IDLE with cpu_reset_=0. Bytes already written stay in memory.
- A full 2**ADDR_W load starting at a nonzero ld_base wraps and overwrites from address 0 upward. No error is raised.

Test Plan:
- Reset, then ld_start with ld_base=0x000 and ld_len=3. Send bytes 0x10, 0x20, 0x30, then checksum 0x60. Required: cpu_reset_ stays 0 until the edge that accepts 0x60, then rises to 1. inst_addr=0x001 gives inst_o=0x20 in the same cycle. ld_error=0.
- Same load with checksum 0x61. Required: ld_error=1, cpu_reset_=0, inst_o=0. Then ld_start with correct data plus checksum 0x60 -> RUN and ld_error=0.
- ld_base=0xFFE, ld_len=4, bytes 0xA1, 0xA2, 0xA3, 0xA4, checksum 0x8A. Required: mem[0xFFE]=0xA1, mem[0xFFF]=0xA2, mem[0x000]=0xA3, mem[0x001]=0xA4, then RUN.
- ld_valid toggled low for 3 cycles between bytes, and ld_start pulsed mid-LOAD with a different ld_len. Required: no extra writes; the original byte count is still honoured.
- From RUN, assert reset_ low asynchronously mid-cycle, then release. Required: cpu_reset_=0 immediately with no clock edge, state IDLE. boot_skip=1 -> RUN next edge, and earlier memory contents are still readable.
- In RUN, pulse ld_start. Required: cpu_reset_=0 on that edge and inst_o=0 until the new load completes.
